multi_clock_divider: RTL

Parametrised, multi-channel successor to the fixed divide-by-2 toggle divider. Each of NUM_CH channels divides clkIn by a runtime-programmable integer and produces a registered divided-clock level and a one-cycle tick strobe. Consumers (game-tick logic, display refresh, debounce timers) use clkOut as a slow level and tick as a same-domain enable. All logic runs on clkIn; no derived clocks drive other logic.

---
 rtl/multi_clock_divider.sv | 80 ++++++++
 1 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: each channel divides clkIn by a runtime
// divisor and produces a registered divided level plus a one-cycle tick strobe.
module multi_clock_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkIn,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync,
  input  logic              cfgWe,
  input  logic [SEL_W-1:0]  cfgSel,
  input  logic [DIV_W-1:0]  cfgDiv,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clkOut,
  output logic [NUM_CH-1:0] tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] shd;
    logic             pend;
    logic             clk_q;
    logic             tick_q;

    logic             wr;
    logic             boundary;
    logic             apply;
    logic [DIV_W-1:0] act_nx;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W:0]   half_nx;

    always_comb begin
      wr = cfgWe && (cfgSel == SEL_W'(i));
      // A stopped channel (act==0) has no wrap to wait for, so a pending divisor
      // counts as a boundary on its own; cnt>=act-1 also recovers an out-of-range cnt.
      if (act == '0) boundary = pend;
      else           boundary = sync || (cnt >= act - 1'b1);
      apply   = boundary && pend;
      act_nx  = apply ? shd : act;
      if (boundary || act == '0) cnt_nx = '0;
      else                       cnt_nx = cnt + 1'b1;
      half_nx = ({1'b0, act_nx} + 1'b1) >> 1;
    end

    always_ff @(posedge clkIn or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        act    <= DIV_W'(DEFAULT_DIV);
        shd    <= DIV_W'(DEFAULT_DIV);
        pend   <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (enable[i]) begin
          cnt    <= cnt_nx;
          act    <= act_nx;
          clk_q  <= (act_nx != '0) && ({1'b0, cnt_nx} < half_nx);
          tick_q <= (act_nx != '0) && boundary;
          if (apply) pend <= 1'b0;
        end else begin
          tick_q <= 1'b0;
        end
        // A write on a boundary edge stays pending for the next boundary.
        if (wr) begin
          shd  <= cfgDiv;
          pend <= 1'b1;
        end
      end
    end

    assign pending[i] = pend;
    assign clkOut[i]  = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule
